// File: rtl/fpusqr_sched_if.sv
// Issue-port / unit-side bundle for the sqrt/div issue scheduler.
// master = FP issue stage side, slave = scheduler side.
interface fpusqr_sched_if #(
  parameter int DEPTH = 4
);
  logic [3:0]  req0_en;
  logic [12:0] req0_op;
  logic [8:0]  req0_regNo;
  logic [9:0]  req0_II;
  logic [3:0]  req1_en;
  logic [12:0] req1_op;
  logic [8:0]  req1_regNo;
  logic [9:0]  req1_II;
  logic [1:0]  req_rdy;
  logic [3:0]  iss_en;
  logic [12:0] iss_op;
  logic [8:0]  iss_regNo;
  logic [9:0]  iss_II;
  logic        busy;
  logic        done;
  logic [9:0]  done_II;
  logic        wb_resv;
  logic [$clog2(DEPTH):0] occ;

  modport master (
    output req0_en, req0_op, req0_regNo, req0_II,
    output req1_en, req1_op, req1_regNo, req1_II,
    input  req_rdy, iss_en, iss_op, iss_regNo, iss_II,
    input  busy, done, done_II, wb_resv, occ
  );

  modport slave (
    input  req0_en, req0_op, req0_regNo, req0_II,
    input  req1_en, req1_op, req1_regNo, req1_II,
    output req_rdy, iss_en, iss_op, iss_regNo, iss_II,
    output busy, done, done_II, wb_resv, occ
  );
endinterface

// File: rtl/fpusqr_sched.sv
// In-order issue scheduler for the iterative FP sqrt/div unit.
// FPUSQR_SCHED_BYPASS_EN: port 0 skips the empty queue when idle.
module fpusqr_sched #(
  parameter int DEPTH = 4,
  parameter int LAT_S = 12,
  parameter int LAT_D = 20,
  parameter int LAT_E = 33,
  parameter int PRE   = 2
) (
  input logic clk,
  input logic rst,
  input logic except,
  fpusqr_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = 8;
  localparam logic [PW-1:0] LIM1 = PW'(DEPTH - 1);
  localparam logic [PW-1:0] LIM2 = PW'(DEPTH - 2);

  typedef struct packed {
    logic [3:0]  en;
    logic [12:0] op;
    logic [8:0]  rn;
    logic [9:0]  ii;
  } ent_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  ent_t          mem [DEPTH];
  logic [PW-1:0] wptr, rptr, occ_q, w1;
  state_t        state;
  logic [CW-1:0] cnt, lat;
  logic [3:0]    iss_en;
  logic [12:0]   iss_op;
  logic [8:0]    iss_rn;
  logic [9:0]    iss_ii, done_ii;

  ent_t ent0, ent1, head, nxt;
  logic [1:0] rdy;
  logic occ_ne, acc0, acc1, byp, pop, launch;

  assign ent0 = {bus.req0_en, bus.req0_op, bus.req0_regNo, bus.req0_II};
  assign ent1 = {bus.req1_en, bus.req1_op, bus.req1_regNo, bus.req1_II};
  assign head = mem[rptr[AW-1:0]];

  assign rdy    = {occ_q <= LIM2, occ_q <= LIM1};
  assign occ_ne = occ_q != '0;

  assign pop = !except && occ_ne &&
    (state == IDLE || (state == RUN && cnt == CW'(1)));

`ifdef FPUSQR_SCHED_BYPASS_EN
  assign byp = !except && !occ_ne && state == IDLE &&
    (bus.req0_en != '0);
`else
  assign byp = 1'b0;
`endif

  assign acc0 = !except && bus.req0_en != '0 && rdy[0] && !byp;
  assign acc1 = !except && bus.req1_en != '0 && rdy[1];
  assign w1   = wptr + PW'(acc0);

  assign launch = byp || pop;
  assign nxt    = byp ? ent0 : head;

  always_comb begin
    lat = CW'(LAT_E);
    unique case (1'b1)
      iss_op[1:0] == 2'd0: lat = CW'(LAT_S);
      iss_op[1:0] == 2'd1: lat = CW'(LAT_D);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      occ_q <= '0;
    end else if (except) begin
      rptr  <= wptr;
      occ_q <= '0;
    end else begin
      wptr  <= wptr + PW'(acc0) + PW'(acc1);
      rptr  <= rptr + PW'(pop);
      occ_q <= occ_q + PW'(acc0) + PW'(acc1) - PW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (acc0 && !rst) mem[wptr[AW-1:0]] <= ent0;
    if (acc1 && !rst) mem[w1[AW-1:0]] <= ent1;
  end

  // iss_en is a one-cycle strobe; the other iss_* hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      iss_en  <= '0;
      iss_op  <= '0;
      iss_rn  <= '0;
      iss_ii  <= '0;
      done_ii <= '0;
    end else if (except) begin
      state  <= IDLE;
      cnt    <= '0;
      iss_en <= '0;
    end else begin
      iss_en <= '0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            iss_en <= nxt.en;
            iss_op <= nxt.op;
            iss_rn <= nxt.rn;
            iss_ii <= nxt.ii;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt     <= lat;
          done_ii <= iss_ii;
          state   <= RUN;
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            cnt <= '0;
            if (launch) begin
              iss_en <= nxt.en;
              iss_op <= nxt.op;
              iss_rn <= nxt.rn;
              iss_ii <= nxt.ii;
              state  <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_rdy   = rdy;
  assign bus.iss_en    = iss_en;
  assign bus.iss_op    = iss_op;
  assign bus.iss_regNo = iss_rn;
  assign bus.iss_II    = iss_ii;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == RUN && cnt == CW'(1);
  assign bus.done_II   = done_ii;
  assign bus.wb_resv   = state == RUN && cnt != '0 &&
                         cnt <= CW'(PRE);
  assign bus.occ       = occ_q;
endmodule

// File: tb/tb_fpusqr_sched.sv
// Bench for fpusqr_sched: directed scenarios then random traffic,
// checked against a per-op schedule model (issue/done cycle per op).
module tb_fpusqr_sched;
  localparam int DEPTH = 4;
  localparam int PRE   = 2;
`ifdef FPUSQR_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic except;
  int   errors = 0;
  int   checks = 0;
  int   t = 0;

  fpusqr_sched_if #(.DEPTH(DEPTH)) b ();

  fpusqr_sched #(
    .DEPTH(DEPTH), .LAT_S(12), .LAT_D(20), .LAT_E(33), .PRE(PRE)
  ) dut (
    .clk(clk), .rst(rst), .except(except), .bus(b.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc;
    int          iss;
    int          dn;
    bit          q;
    logic [3:0]  en;
    logic [12:0] op;
    logic [8:0]  rn;
    logic [9:0]  ii;
  } rec_t;

  rec_t ops[$];

  function automatic int lat(input logic [1:0] p);
    if (p == 2'd0) return 12;
    if (p == 2'd1) return 20;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  task automatic chk_zero_regs();
    chk("rst_iss_op", 32'(b.iss_op), 32'd0);
    chk("rst_iss_rn", 32'(b.iss_regNo), 32'd0);
    chk("rst_iss_ii", 32'(b.iss_II), 32'd0);
    chk("rst_done_ii", 32'(b.done_II), 32'd0);
  endtask

  task automatic step(
    input logic [3:0] e0, input logic [12:0] o0,
    input logic [8:0] r0, input logic [9:0] i0,
    input logic [3:0] e1, input logic [12:0] o1,
    input logic [8:0] r1, input logic [9:0] i1,
    input bit ex, input bit rs);
    int occ_m, ld;
    bit busy_m, done_m, wb_m, a0, a1, b0;
    logic [3:0] ie;
    logic [12:0] io;
    logic [8:0] ir;
    logic [9:0] ii, dii;
    logic [1:0] rdy_m;
    rec_t r;
    occ_m = 0; busy_m = 0; done_m = 0; wb_m = 0;
    ie = '0; io = '0; ir = '0; ii = '0; dii = '0;
    foreach (ops[k]) begin
      if (ops[k].q && ops[k].acc < t && t < ops[k].iss) occ_m++;
      if (ops[k].iss <= t && t <= ops[k].dn) busy_m = 1;
      if (ops[k].iss == t) begin
        ie = ops[k].en; io = ops[k].op;
        ir = ops[k].rn; ii = ops[k].ii;
      end
      if (ops[k].dn == t) begin done_m = 1; dii = ops[k].ii; end
      if (t > ops[k].dn - PRE && t <= ops[k].dn) wb_m = 1;
    end
    rdy_m = {occ_m <= DEPTH - 2, occ_m <= DEPTH - 1};
    chk("occ", 32'(b.occ), 32'(occ_m));
    chk("req_rdy", 32'(b.req_rdy), 32'(rdy_m));
    chk("iss_en", 32'(b.iss_en), 32'(ie));
    if (ie != '0) begin
      chk("iss_op", 32'(b.iss_op), 32'(io));
      chk("iss_regNo", 32'(b.iss_regNo), 32'(ir));
      chk("iss_II", 32'(b.iss_II), 32'(ii));
    end
    chk("busy", 32'(b.busy), 32'(busy_m));
    chk("done", 32'(b.done), 32'(done_m));
    if (done_m) chk("done_II", 32'(b.done_II), 32'(dii));
    chk("wb_resv", 32'(b.wb_resv), 32'(wb_m));

    b.req0_en = e0; b.req0_op = o0; b.req0_regNo = r0; b.req0_II = i0;
    b.req1_en = e1; b.req1_op = o1; b.req1_regNo = r1; b.req1_II = i1;
    except = ex; rst = rs;
    if (rs || ex) begin
      ops.delete();
    end else begin
      ld = (ops.size() > 0) ? ops[$].dn : -100;
      a0 = e0 != '0 && rdy_m[0];
      a1 = e1 != '0 && rdy_m[1];
      b0 = BYP && a0 && occ_m == 0 && !busy_m;
      if (a0) begin
        r.acc = t; r.q = !b0;
        r.iss = b0 ? t + 1 : ((t + 2 > ld + 1) ? t + 2 : ld + 1);
        r.dn = r.iss + lat(o0[1:0]);
        r.en = e0; r.op = o0; r.rn = r0; r.ii = i0;
        ops.push_back(r);
        ld = r.dn;
      end
      if (a1) begin
        r.acc = t; r.q = 1'b1;
        r.iss = (t + 2 > ld + 1) ? t + 2 : ld + 1;
        r.dn = r.iss + lat(o1[1:0]);
        r.en = e1; r.op = o1; r.rn = r1; r.ii = i1;
        ops.push_back(r);
      end
    end
    @(posedge clk); #1;
    t++;
    while (ops.size() > 0 && ops[0].dn < t - 2) void'(ops.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic one(input logic [12:0] o, input logic [9:0] i);
    step(4'h1, o, 9'd7, i, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic two(input logic [12:0] o0, input logic [9:0] i0,
                     input logic [12:0] o1, input logic [9:0] i1);
    step(4'h3, o0, 9'd11, i0, 4'hf, o1, 9'd12, i1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; except = 1'b0;
    b.req0_en = '0; b.req0_op = '0; b.req0_regNo = '0; b.req0_II = '0;
    b.req1_en = '0; b.req1_op = '0; b.req1_regNo = '0; b.req1_II = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_regs();

    // single double-precision op
    one(13'd1, 10'd5);
    idle(25);

    // dual-port ordering: single then extended
    two(13'd0, 10'd1, 13'd2, 10'd2);
    idle(60);

    // full queue behind a running op, then a dropped fifth request
    one(13'd2, 10'd20);
    idle(3);
    two(13'd3, 10'd21, 13'd2, 10'd22);
    two(13'd2, 10'd23, 13'd6, 10'd24);
    one(13'd2, 10'd25);
    two(13'd0, 10'd26, 13'd1, 10'd27);
    idle(180);

    // partial room: occ=3 drops port 1
    one(13'd1, 10'd30);
    idle(3);
    two(13'd0, 10'd31, 13'd0, 10'd32);
    one(13'd0, 10'd33);
    two(13'd0, 10'd34, 13'd0, 10'd35);
    idle(90);

    // flush mid-run with two queued entries
    one(13'd1, 10'd40);
    two(13'd0, 10'd41, 13'd0, 10'd42);
    idle(14);
    step('0, '0, '0, '0, 4'h1, 13'd0, 9'd1, 10'd43, 1'b1, 1'b0);
    idle(40);
    one(13'd0, 10'd44);
    idle(20);

    // reset mid-run
    one(13'd2, 10'd50);
    two(13'd0, 10'd51, 13'd1, 10'd52);
    idle(10);
    step(4'h1, 13'd0, 9'd1, 10'd53, '0, '0, '0, '0, 1'b0, 1'b1);
    chk_zero_regs();
    idle(5);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] e0, e1;
      bit ex, rs;
      e0 = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      e1 = ($urandom % 4 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ex = ($urandom % 150 == 0);
      rs = ($urandom % 400 == 0);
      step(e0, 13'($urandom), 9'($urandom), 10'($urandom),
           e1, 13'($urandom), 9'($urandom), 10'($urandom), ex, rs);
    end
    idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpusqr_sched.md
# fpusqr_sched

Issue scheduler for the iterative FP square-root/divide unit (`fun_fpusqr`). It accepts sqrt/div requests from two issue ports into a small in-order queue. It launches them one at a time onto the unit's `u1_*` inputs and counts down the precision-dependent latency. Before each result appears it reserves the shared writeback slot. It sits between the FP issue stage and the `fun_fpusqr` instance, and flushes on exception.

## Interface
Parameters:
- `DEPTH`, 4: queue entries (power of two, ≥2).
- `LAT_S`, 12: cycles from `iss_en` to `done` for single precision.
- `LAT_D`, 20: latency for double precision.
- `LAT_E`, 33: latency for extended precision.
- `PRE`, 2: writeback-reservation lead in cycles; must be less than every `LAT_*`.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `except`  in  1  pipeline flush.
- `req0_en`  in  4  lane enables; a request is present when the value is nonzero.
- `req0_op`  in  13  operation; `[1:0]` selects precision.
- `req0_regNo`  in  9  destination register.
- `req0_II`  in  10  instruction index.
- `req1_en`, `req1_op`, `req1_regNo`, `req1_II`  in  4/13/9/10  second issue port, same meaning as port 0.
- `req_rdy`  out  2  per-port accept.
- `iss_en`  out  4  to `u1_en`.
- `iss_op`  out  13  to `u1_op`.
- `iss_regNo`  out  9  to `u1_regNo`.
- `iss_II`  out  10  to `u1_II`.
- `busy`  out  1  unit occupied.
- `done`  out  1  result-cycle pulse.
- `done_II`  out  10  instruction index of the completing op.
- `wb_resv`  out  1  writeback slot reservation.
- `occ`  out  3  queue occupancy.

## Operation
- Queue: circular FIFO with read/write pointers `log2(DEPTH)+1` bits wide; the extra bit distinguishes full from empty. Each entry holds en, op, regNo, II.
- Accept rule:
  - `req_rdy[0]` = free ≥ 1; `req_rdy[1]` = free ≥ 2.
  - Both are combinational from the start-of-cycle `occ` and ignore a same-cycle pop.
  - Port 0 is written before port 1 when both are accepted in one cycle.
  - A request with `en` nonzero while its `req_rdy` bit is low is dropped; the issue stage must hold it.
- Latency select:
  - `op[1:0]` = 0 → `LAT_S`; 1 → `LAT_D`; 2 or 3 → `LAT_E`.
- FSM (state register reset to IDLE):
  - IDLE: if the queue is non-empty, pop the head into the issue registers → ISSUE.
  - ISSUE: `iss_*` valid for exactly one cycle; counter loaded with L → RUN.
  - RUN: counter decrements each cycle. At counter==1, `done` is high and `done_II` = II of that op.
    - If the queue is non-empty in that same cycle, pop → ISSUE (back-to-back: the next `iss_en` is one cycle after `done`).
    - Otherwise → IDLE.
- `busy` = state != IDLE.
- `wb_resv` = RUN and 1 ≤ counter ≤ PRE; it includes the `done` cycle.
- Flush (`except` = 1):
  - next cycle: queue empty, counter 0, state IDLE;
  - `iss_en` is 0 and `done`/`wb_resv` are low from the next cycle onward;
  - requests presented in the `except` cycle are dropped;
  - an in-flight unit result is discarded by the unit's own except path.
- Reset: same effect as flush, plus the pointers are zeroed.
- Ordering: strict FIFO; completion order equals acceptance order.

## Timing
- Reset values:
  - `iss_en`=0, `iss_op`=0, `iss_regNo`=0, `iss_II`=0;
  - `busy`=0, `done`=0, `done_II`=0, `wb_resv`=0, `occ`=0;
  - `req_rdy`=2'b11.
- Registered outputs: all `iss_*`, `done_II`, `occ`. `req_rdy`, `busy`, `done` and `wb_resv` are decoded from registers with no input-to-output combinational path.
- Accept-to-issue latency with an empty queue and an idle unit: request accepted at T, popped at T+1, `iss_en` high at T+2.
- Issue-to-done latency: `done` is high at `iss_en` cycle + L.
- Throughput: one op per L+1 cycles.
- Full queue: with `occ`=DEPTH, `req_rdy`=00. A pop in the same cycle does not raise `req_rdy` until the next cycle.
- `rst` has priority over `except`; `except` has priority over accept and pop.

## Configuration
- Macro: `FPUSQR_SCHED_BYPASS_EN`.
- Defined:
  - When the queue is empty, the state is IDLE and `req0_en` is nonzero, port 0 loads the issue registers directly, so `iss_en` is high at T+1.
  - A simultaneous port-1 request is enqueued normally.
- Undefined: every request passes through the queue (T+2 issue).
- Latency to `done` from `iss_en` is unchanged in both builds.

## Test plan
- Single request: one double-precision op (op[1:0]=1, II=5) into an idle scheduler → `iss_en` at T+2 (T+1 with bypass), `done` with `done_II`=5 exactly 20 cycles after `iss_en`, `wb_resv` high on the last 2 cycles including the `done` cycle.
- Dual-port ordering: ports 0/1 present II=1 (single) and II=2 (extended) in one cycle → issues in order 1 then 2; second `iss_en` one cycle after the first `done`; second `done` 33 cycles later.
- Full queue: 4 extended ops queued behind a running op → `occ`=4, `req_rdy`=00; a fifth request is not accepted; after the next pop `req_rdy[0]`=1 one cycle later.
- Partial room: `occ`=3 → `req_rdy`=01; a simultaneous port-1 request is dropped and only the port-0 request is written.
- Flush mid-run: `except` at counter=7 with 2 entries queued → next cycle `busy`=0, `occ`=0, no `done` pulse ever; a new request then issues at T+2.
- Reset mid-run: `rst` pulse during RUN → all outputs at reset values the next cycle; `req_rdy`=11.
